// File: rtl/sm_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : sm_muldiv
// Brief    : Iterative multiply/divide unit with private HI/LO registers.
//            MULTU/MULT/DIVU/DIV take WIDTH iteration cycles behind a
//            start/busy/done handshake; MTHI/MTLO complete in one cycle.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start, oper         - request strobe and operation select
//                                  (000 MULTU, 001 MULT, 010 DIVU, 011 DIV,
//                                   100 MTHI, 101 MTLO, 11x no-op)
//            srcA, srcB          - operands (srcA also MTHI/MTLO data)
//            busy                - iterative operation in progress
//            done, divZero       - one-cycle completion / divide-by-zero pulse
//            hi, lo              - HI and LO result registers
// Revision : 1.0 - initial release
// ============================================================================
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                    c_cntWidth = $clog2(WIDTH + 1);
    localparam logic [c_cntWidth-1:0] c_cntInit  = c_cntWidth'(WIDTH);
    localparam logic [c_cntWidth-1:0] c_cntOne   = c_cntWidth'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_cntWidth-1:0]   r_cnt;
    logic [2*WIDTH-1:0]      r_acc;     // {partial product | remainder, multiplier | dividend->quotient}
    logic [WIDTH-1:0]        r_b;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]        r_origA;   // raw srcA, returned in HI on divide-by-zero
    logic                    r_signA;
    logic                    r_signB;
    logic                    r_signed;
    logic                    r_isDiv;
    logic                    r_bZero;
    logic                    r_done;
    logic                    r_divZero;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;

    logic                    w_accept;
    logic [WIDTH-1:0]        w_magA;
    logic [WIDTH-1:0]        w_magB;
    logic [WIDTH:0]          w_mulSum;
    logic [2*WIDTH-1:0]      w_mulNext;
    logic [WIDTH:0]          w_shift;
    logic                    w_fits;
    logic [WIDTH-1:0]        w_divRem;
    logic [2*WIDTH-1:0]      w_divNext;
    logic [2*WIDTH-1:0]      w_accNext;
    logic                    w_negRes;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH-1:0]        w_quo;
    logic [WIDTH-1:0]        w_rem;
    logic [WIDTH-1:0]        w_quoS;
    logic [WIDTH-1:0]        w_remS;

    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign divZero = r_divZero;
    assign hi      = r_hi;
    assign lo      = r_lo;

    assign w_accept = start & ~busy;

    // Signed ops work on magnitudes; |MIN| wraps to MIN, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign w_magA = (oper[0] & srcA[WIDTH-1]) ? -srcA : srcA;
    assign w_magB = (oper[0] & srcB[WIDTH-1]) ? -srcB : srcB;

    // Shift-add multiply: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mulNext = r_acc[0] ? {w_mulSum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder is always below the
    // divisor, so a fitting difference never exceeds WIDTH bits.
    assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_fits    = (w_shift >= {1'b0, r_b});
    assign w_divRem  = w_shift[WIDTH-1:0] - r_b;
    assign w_divNext = w_fits ? {w_divRem,           r_acc[WIDTH-2:0], 1'b1}
                              : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_accNext = r_isDiv ? w_divNext : w_mulNext;

    // Sign fix-up applied to the accumulator value produced on the last edge.
    assign w_negRes = r_signed & (r_signA ^ r_signB);
    assign w_prod   = w_negRes ? -w_accNext : w_accNext;
    assign w_quo    = w_accNext[WIDTH-1:0];
    assign w_rem    = w_accNext[2*WIDTH-1:WIDTH];
    assign w_quoS   = w_negRes ? -w_quo : w_quo;
    assign w_remS   = (r_signed & r_signA) ? -w_rem : w_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_origA   <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_signed  <= 1'b0;
            r_isDiv   <= 1'b0;
            r_bZero   <= 1'b0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (oper)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_state  <= S_RUN;
                                r_cnt    <= c_cntInit;
                                r_acc    <= {{WIDTH{1'b0}}, w_magA};
                                r_b      <= w_magB;
                                r_origA  <= srcA;
                                r_signA  <= srcA[WIDTH-1];
                                r_signB  <= srcB[WIDTH-1];
                                r_signed <= oper[0];
                                r_isDiv  <= oper[1];
                                r_bZero  <= (srcB == '0);
                            end
                            3'b100:  r_hi <= srcA;
                            3'b101:  r_lo <= srcA;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt - c_cntOne;
                    if (r_cnt == c_cntOne) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_divZero <= r_isDiv & r_bZero;
                        if (r_isDiv) begin
                            if (r_bZero) begin
                                r_hi <= r_origA;
                                r_lo <= '1;
                            end else begin
                                r_hi <= w_remS;
                                r_lo <= w_quoS;
                            end
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_muldiv
// Brief    : Self-checking bench for sm_muldiv (WIDTH=32). A cycle-level
//            reference built from plain 64-bit arithmetic is compared against
//            the DUT on every falling edge; directed cases pin hand-computed
//            results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    oper;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          busy;
    logic          done;
    logic          divZero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    sm_muldiv #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .oper    (oper),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural result {divZero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] u, q64, r64;
        logic [64:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            3'd0: begin
                u   = {32'b0, a} * {32'b0, b};
                res = {1'b0, u};
            end
            3'd1: begin
                sp  = sa * sb;
                u   = 64'(sp);
                res = {1'b0, u};
            end
            3'd2: begin
                if (b == '0) res = {1'b1, a, 32'hFFFF_FFFF};
                else         res = {1'b0, a % b, a / b};
            end
            3'd3: begin
                if (b == '0) res = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    q64 = 64'(sq);
                    r64 = 64'(sr);
                    res = {1'b0, r64[31:0], q64[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Cycle-level reference: an accepted mul/div becomes visible W edges later.
    logic         m_busy, m_done, m_dz, p_dz;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int           m_remain;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_dz     <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
            p_dz     <= 1'b0;
            p_hi     <= '0;
            p_lo     <= '0;
            m_remain <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_remain > 0) begin
                if (m_remain == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_dz   <= p_dz;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_remain <= m_remain - 1;
            end else if (start) begin
                if (oper <= 3'd3) begin
                    {p_dz, p_hi, p_lo} <= model(oper, srcA, srcB);
                    m_remain <= W;
                    m_busy   <= 1'b1;
                end else if (oper == 3'd4) begin
                    m_hi <= srcA;
                end else if (oper == 3'd5) begin
                    m_lo <= srcA;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn && !rst) begin
            check("cyc_busy",    busy,    m_busy);
            check("cyc_done",    done,    m_done);
            check("cyc_divZero", divZero, m_dz);
            check("cyc_hi",      hi,      m_hi);
            check("cyc_lo",      lo,      m_lo);
        end
    end

    // Issue one request at a falling edge; operands are scrambled afterwards.
    task automatic doOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        oper  = 3'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // Advance to the falling edge where done is high, counting busy cycles.
    task automatic waitDone(output int nBusy);
        bit seen;
        int i;
        seen  = 1'b0;
        i     = 0;
        nBusy = 0;
        while (!seen && i < 40) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) nBusy++;
                @(negedge clk);
                i++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=timeout required=done within 40 cycles");
        end
    endtask

    task automatic chkRes(input string name, input logic [W-1:0] eHi, input logic [W-1:0] eLo, input logic eDz);
        check({name, "_hi"},   hi,      eHi);
        check({name, "_lo"},   lo,      eLo);
        check({name, "_dz"},   divZero, eDz);
        check({name, "_done"}, done,    1'b1);
    endtask

    initial begin
        int nb;
        int doneSeen;
        rst   = 1'b1;
        start = 1'b0;
        oper  = 3'd0;
        srcA  = '0;
        srcB  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy,    1'b0);
        check("reset_done", done,    1'b0);
        check("reset_dz",   divZero, 1'b0);
        check("reset_hi",   hi,      32'h0);
        check("reset_lo",   lo,      32'h0);
        rst     = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);

        doOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(nb);
        check("multu_busy_cycles", 64'(nb), 64'd32);
        chkRes("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("multu_done_single", done, 1'b0);

        doOp(3'd1, 32'hFFFF_FFFD, 32'd7);
        waitDone(nb);
        chkRes("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        doOp(3'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
        waitDone(nb);
        chkRes("mult_m4xm5", 32'h0, 32'h14, 1'b0);

        doOp(3'd2, 32'd100, 32'd7);
        waitDone(nb);
        chkRes("divu_100_7", 32'd2, 32'd14, 1'b0);

        doOp(3'd3, 32'hFFFF_FFF9, 32'd2);
        waitDone(nb);
        chkRes("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        doOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(nb);
        chkRes("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

        doOp(3'd2, 32'd5, 32'd0);
        waitDone(nb);
        check("divu_zero_cycles", 64'(nb), 64'd32);
        chkRes("divu_5_0", 32'd5, 32'hFFFF_FFFF, 1'b1);

        doOp(3'd3, 32'hFFFF_FFF7, 32'd0);
        waitDone(nb);
        chkRes("div_m9_0", 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);

        @(negedge clk);
        doOp(3'd4, 32'h0000_1234, 32'd0);
        check("mthi_hi",   hi,   32'h0000_1234);
        check("mthi_busy", busy, 1'b0);
        check("mthi_done", done, 1'b0);

        // MTLO issued while a MULT is busy must be ignored.
        doOp(3'd1, 32'd6, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        start = 1'b1;
        oper  = 3'd5;
        srcA  = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        waitDone(nb);
        chkRes("mult_mtlo_ignored", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

        // Back-to-back: MTHI accepted in the done cycle overwrites HI.
        doOp(3'd0, 32'd3, 32'd5);
        waitDone(nb);
        chkRes("multu_3x5", 32'd0, 32'd15, 1'b0);
        doOp(3'd4, 32'h0000_AAAA, 32'd0);
        check("b2b_mthi_hi", hi, 32'h0000_AAAA);
        check("b2b_mthi_lo", lo, 32'd15);

        // Reset in the middle of a DIVU.
        doOp(3'd2, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy,    1'b0);
        check("midrst_done", done,    1'b0);
        check("midrst_dz",   divZero, 1'b0);
        check("midrst_hi",   hi,      32'h0);
        check("midrst_lo",   lo,      32'h0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        check("midrst_no_done", 64'(doneSeen), 64'd0);
        doOp(3'd2, 32'd1000, 32'd3);
        waitDone(nb);
        chkRes("divu_after_rst", 32'd1, 32'd333, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
